// File: rtl/ham_dec.sv
// ham_dec: decodes a 34-bit tagged word into a 32-bit data word and a 2-bit
// mode, buffered through a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional per-mode accepted-word statistics are built only when the macro
// HAM_DEC_STATS_EN is defined; otherwise the stat outputs are tied to zero.
module ham_dec #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [33:0]      in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_mode,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_inv,
  output logic [CNT_W-1:0] stat_swp,
  output logic [CNT_W-1:0] stat_iel,
  output logic [CNT_W-1:0] stat_iol
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t        occ, occ_nxt;
  logic        in_ready_q;
  logic        wr_ptr, rd_ptr;
  logic [31:0] mem_data [2];
  logic [1:0]  mem_mode [2];
  logic [31:0] dec_data;
  logic [31:0] payload;
  logic        push, pop;

  assign payload   = in_code[33:2];
  assign push      = in_valid & in_ready_q;
  assign pop       = (occ != OCC_EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = mem_data[rd_ptr];
  assign out_mode  = mem_mode[rd_ptr];

  // Combinational decode of the incoming payload according to its mode tag
  always_comb begin
    dec_data = '0;
    case (in_code[1:0])
      2'b00: dec_data = ~payload;
      2'b01: begin
        for (int unsigned k = 0; k < 16; k++) begin
          dec_data[2*k]   = payload[2*k+1];
          dec_data[2*k+1] = payload[2*k];
        end
      end
      2'b10: dec_data = payload ^ 32'h5555_5555;
      default: dec_data = payload ^ 32'hAAAA_AAAA;
    endcase
  end

  // Next occupancy from push/pop; simultaneous push and pop holds occupancy
  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_nxt = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_nxt = occ;
    endcase
  end

  // Occupancy register; in_ready is registered from the next occupancy so it
  // has no combinational dependence on out_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ        <= OCC_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      occ        <= occ_nxt;
      in_ready_q <= (occ_nxt != OCC_FULL);
    end
  end

  // FIFO storage and 1-bit pointers that wrap modulo 2
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_mode[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= dec_data;
        mem_mode[wr_ptr] <= in_code[1:0];
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

`ifdef HAM_DEC_STATS_EN
  logic [CNT_W-1:0] cnt [4];

  // Saturating per-mode counters of accepted words; clear wins over increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (push && (cnt[in_code[1:0]] != '1)) begin
      cnt[in_code[1:0]] <= cnt[in_code[1:0]] + CNT_W'(1);
    end
  end

  assign stat_inv = cnt[0];
  assign stat_swp = cnt[1];
  assign stat_iel = cnt[2];
  assign stat_iol = cnt[3];
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_inv = '0;
  assign stat_swp = '0;
  assign stat_iel = '0;
  assign stat_iol = '0;
`endif

endmodule

// File: doc/ham_dec.md
HAM_DEC -- requirements
Module: ham_dec

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of each per-mode statistics counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 in_code  input  34  encoded word; [33:2] payload, [1:0] mode tag.
REQ-005 in_valid  input  1  in_code valid this cycle.
REQ-006 in_ready  output  1  decoder can accept a word this cycle.
REQ-007 out_data  output  32  decoded data word.
REQ-008 out_mode  output  2  mode tag of the word on out_data.
REQ-009 out_valid  output  1  out_data/out_mode valid.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 stat_clr  input  1  synchronous clear of all statistics counters.
REQ-012 stat_inv, stat_swp, stat_iel, stat_iol  output  CNT_W each  accepted-word counts per mode 00/01/10/11.

Function
REQ-013 Decode, P = in_code[33:2]: mode 00 -> data = ~P; mode 01 -> data[2k] = P[2k+1] and data[2k+1] = P[2k] for k = 0..15; mode 10 -> data = P ^ 32'h5555_5555; mode 11 -> data = P ^ 32'hAAAA_AAAA.
REQ-014 Decoding SHALL be combinational on the input side; decoded data and tag SHALL be written into a 2-entry FIFO on accept.
REQ-015 Accept SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (occupancy != 2) and SHALL be registered (no combinational path from out_ready).
REQ-017 out_valid SHALL equal (occupancy != 0); out_data/out_mode SHALL present the head entry.
REQ-018 Latency: a word accepted in cycle N into an empty FIFO SHALL appear with out_valid=1 in cycle N+1.
REQ-019 Throughput: with out_ready held 1, SHALL sustain one word per cycle with no bubbles.
REQ-020 Simultaneous accept and transfer SHALL leave occupancy unchanged, the new word queued behind the remaining entry.
REQ-021 When occupancy is 2, in_ready=0 for that cycle even if out_ready=1; a word presented then SHALL NOT be accepted and SHALL be held by the sender.
REQ-022 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-023 out_data/out_mode SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 FIFO read/write pointers SHALL wrap modulo 2.

Reset
REQ-025 While resetn=0: occupancy = 0, out_valid = 0, in_ready = 0, out_data = 0, out_mode = 0, all stat counters = 0.
REQ-026 in_ready SHALL rise in the first clock edge after resetn deasserts.
REQ-027 Reset mid-operation SHALL discard all buffered words immediately (asynchronously).

Configuration
REQ-028 Macro HAM_DEC_STATS_EN defined: each accepted word SHALL increment the counter for its mode, saturating at all-ones.
REQ-029 With HAM_DEC_STATS_EN defined: stat_clr=1 SHALL zero all counters at the next edge and take priority over an increment in the same cycle.
REQ-030 Macro HAM_DEC_STATS_EN undefined: ports SHALL remain present, all stat outputs SHALL be constant 0, stat_clr SHALL be ignored, and no counter logic SHALL be synthesized.

Verification
REQ-031 in_code = {32'hEDCB_A987, 2'b00}, out_ready=1 -> next cycle out_data = 32'h1234_5678, out_mode = 00.
REQ-032 in_code = 34'h0_0000_0009 (payload 32'h2, mode 01) -> out_data = 32'h0000_0001; payload 32'h5555_5555 mode 10 -> 32'h0; payload 32'hAAAA_AAAA mode 11 -> 32'h0.
REQ-033 out_ready=0, offer words A, B, C back-to-back -> A and B accepted, in_ready=0 and C held; then out_ready=1 -> outputs A, B, C in order with no loss.
REQ-034 Continuous in_valid=1, out_ready=1, 100 random words -> 100 outputs, each 1 cycle after accept, matching the reference decode.
REQ-035 resetn pulsed low with 2 words buffered -> out_valid = 0 at once; after release, in_ready=1 next edge and no stale word is emitted.
REQ-036 With HAM_DEC_STATS_EN: 3 words mode 10 and 1 word mode 00 -> stat_iel = 3, stat_inv = 1; stat_clr pulse -> all counters 0; with CNT_W=2, 5 words mode 01 -> stat_swp = 3 (saturated).
